// File: rtl/pipeline_pkg.sv
// Shared types and default constants for the pipeline controller.
package pipeline_pkg;

   localparam int DEF_NUM_STAGES    = 5;
   localparam int DEF_NUM_STALL_SRC = 2;
   localparam int DEF_HAZ_STAGE     = 2;
   localparam int DEF_TIMEOUT       = 1024;
   localparam int DEF_CNT_W         = 32;
   localparam int MAX_STAGES        = 8;

   // Trap sequencer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_REDIRECT = 2'd3
   } pipe_state_e;

   // Index of the oldest (highest-numbered) erroring stage; the last stage is excluded.
   function automatic int oldest_err(input logic [MAX_STAGES-1:0] err, input int num_stages);
      int idx;
      idx = 0;
      for (int k = 0; k < MAX_STAGES; k++) begin
         if ((k < num_stages - 1) && err[k]) begin
            idx = k;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall watchdog with sticky timeout flag, plus a free-running
// count of cycles in which the whole pipeline was held.
module stall_watchdog
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_any_i,
   input  logic             pipe_stall_i,
   input  logic             timeout_clr_i,
   output logic             stall_timeout_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   localparam int              WD_W   = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
   localparam logic [CNT_W-1:0] CY_ONE = CNT_W'(1);

   logic [WD_W-1:0]  wd_q, wd_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;

   // Next-state: saturating stall run length, sticky flag (set beats clear), wrapping cycle count
   always_comb begin
      wd_d      = wd_q;
      timeout_d = timeout_q;
      cycles_d  = cycles_q;
      if (stall_any_i) begin
         if (wd_q < WD_MAX) begin
            wd_d = wd_q + WD_ONE;
         end else begin
            wd_d = WD_MAX;
         end
      end else begin
         wd_d = {WD_W{1'b0}};
      end
      if (stall_any_i && (wd_d == WD_MAX)) begin
         timeout_d = 1'b1;
      end else if (timeout_clr_i) begin
         timeout_d = 1'b0;
      end else begin
         timeout_d = timeout_q;
      end
      if (pipe_stall_i) begin
         cycles_d = cycles_q + CY_ONE;
      end else begin
         cycles_d = cycles_q;
      end
   end

   // Counter and flag registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_q      <= {WD_W{1'b0}};
         timeout_q <= 1'b0;
         cycles_q  <= {CNT_W{1'b0}};
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
         cycles_q  <= cycles_d;
      end
   end

   assign stall_timeout_o = timeout_q;
   assign stall_cycles_o  = cycles_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/stall/trap controller: combinational per-stage stall and
// flush masks, a four-state trap sequencer and a stall watchdog.
module pipeline_controller
   import pipeline_pkg::*;
#(
   parameter int NUM_STAGES    = DEF_NUM_STAGES,
   parameter int NUM_STALL_SRC = DEF_NUM_STALL_SRC,
   parameter int HAZ_STAGE     = DEF_HAZ_STAGE,
   parameter int TIMEOUT       = DEF_TIMEOUT,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_data_hazard,
   input  logic                          i_control_hazard,
   input  logic [NUM_STALL_SRC-1:0]      i_stall_req,
   input  logic [NUM_STAGES-1:0]         i_err,
   input  logic                          i_mem_busy,
   input  logic                          i_timeout_clr,
   output logic [NUM_STAGES-1:0]         o_stall,
   output logic [NUM_STAGES-1:0]         o_flush,
   output logic                          o_redirect,
   output logic [$clog2(NUM_STAGES)-1:0] o_trap_stage,
   output logic                          o_trap_active,
   output logic                          o_stall_timeout,
   output logic [CNT_W-1:0]              o_stall_cycles
);

   localparam int                   TS_W       = $clog2(NUM_STAGES);
   localparam logic [NUM_STAGES-1:0] ONE_MASK   = {{(NUM_STAGES-1){1'b0}}, 1'b1};
   localparam logic [NUM_STAGES-1:0] ALL_MASK   = {NUM_STAGES{1'b1}};
   localparam logic [NUM_STAGES-1:0] TAIL_MASK  = {{(NUM_STAGES-1){1'b1}}, 1'b0};
   localparam logic [NUM_STAGES-1:0] FRONT_MASK = (ONE_MASK << HAZ_STAGE) - ONE_MASK;
   localparam logic [NUM_STAGES-1:0] HAZ_MASK   = ONE_MASK << HAZ_STAGE;
   localparam logic [NUM_STAGES-1:0] CTRL_MASK  = FRONT_MASK << 1;

   pipe_state_e           state_q, state_d;
   logic [TS_W-1:0]       trap_stage_q, trap_stage_d;
   logic [MAX_STAGES-1:0] err_ext_s;
   logic                  err_any_s;
   logic                  stall_any_s;
   int                    err_idx_s;
   logic [NUM_STAGES-1:0] stall_s, flush_s;
   logic                  redirect_s;

   // Decode hazards/errors into stage masks and choose the next trap state
   always_comb begin
      state_d      = state_q;
      trap_stage_d = trap_stage_q;
      stall_s      = {NUM_STAGES{1'b0}};
      flush_s      = {NUM_STAGES{1'b0}};
      redirect_s   = 1'b0;
      err_ext_s    = {MAX_STAGES{1'b0}};
      err_ext_s[NUM_STAGES-1:0] = i_err;
      err_any_s    = |i_err[NUM_STAGES-2:0];
      err_idx_s    = oldest_err(err_ext_s, NUM_STAGES);
      stall_any_s  = |i_stall_req;
      case (state_q)
         ST_IDLE: begin
            if (err_any_s) begin
               flush_s      = ((ONE_MASK << (err_idx_s + 1)) - ONE_MASK) << 1;
               trap_stage_d = TS_W'(err_idx_s);
               state_d      = ST_FLUSH;
            end else if (stall_any_s) begin
               stall_s = ALL_MASK;
            end else if (i_control_hazard) begin
               flush_s = CTRL_MASK;
            end else if (i_data_hazard) begin
               stall_s = FRONT_MASK;
               flush_s = HAZ_MASK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            stall_s = ONE_MASK;
            flush_s = TAIL_MASK;
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            stall_s = ONE_MASK;
            if (i_mem_busy) begin
               flush_s = TAIL_MASK;
            end else begin
               state_d = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            redirect_s = 1'b1;
            flush_s    = ONE_MASK;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Reset forces bubbles everywhere and suppresses any redirect
      if (i_rst) begin
         stall_s    = {NUM_STAGES{1'b0}};
         flush_s    = ALL_MASK;
         redirect_s = 1'b0;
      end else begin
         redirect_s = redirect_s;
      end
   end

   // Trap state and trapped-stage registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         trap_stage_q <= {TS_W{1'b0}};
      end else begin
         state_q      <= state_d;
         trap_stage_q <= trap_stage_d;
      end
   end

   stall_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk_i           (i_clk),
      .rst_i           (i_rst),
      .stall_any_i     (stall_any_s && (state_q == ST_IDLE)),
      .pipe_stall_i    (stall_s[NUM_STAGES-1]),
      .timeout_clr_i   (i_timeout_clr),
      .stall_timeout_o (o_stall_timeout),
      .stall_cycles_o  (o_stall_cycles)
   );

   assign o_stall       = stall_s;
   assign o_flush       = flush_s;
   assign o_redirect    = redirect_s;
   assign o_trap_stage  = trap_stage_q;
   assign o_trap_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller (5 stages, hazard stage 2, timeout 8).
module tb_pipeline_controller;

   localparam int NS  = 5;
   localparam int HZ  = 2;
   localparam int TO  = 8;
   localparam int CW  = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          dh, ch, mb, tc;
   logic [1:0]    sr;
   logic [NS-1:0] er;
   logic [NS-1:0] o_stall, o_flush;
   logic          o_redirect, o_trap_active, o_stall_timeout;
   logic [2:0]    o_trap_stage;
   logic [CW-1:0] o_stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: trap phase 0 = none, 1 = flushing, 2 = draining, 3 = redirecting
   int          m_phase;
   int          m_trap;
   int          m_run;
   bit          m_to;
   logic [31:0] m_cycles;

   pipeline_controller #(
      .NUM_STAGES(NS), .NUM_STALL_SRC(2), .HAZ_STAGE(HZ), .TIMEOUT(TO), .CNT_W(CW)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_data_hazard(dh), .i_control_hazard(ch),
      .i_stall_req(sr), .i_err(er), .i_mem_busy(mb), .i_timeout_clr(tc),
      .o_stall(o_stall), .o_flush(o_flush), .o_redirect(o_redirect),
      .o_trap_stage(o_trap_stage), .o_trap_active(o_trap_active),
      .o_stall_timeout(o_stall_timeout), .o_stall_cycles(o_stall_cycles)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_trap = 0; m_run = 0; m_to = 0; m_cycles = 32'd0;
   endtask

   function automatic int oldest(input logic [NS-1:0] e);
      int r;
      r = -1;
      for (int k = 0; k < NS - 1; k++) if (e[k]) r = k;
      return r;
   endfunction

   task automatic step(input logic r, input logic d, input logic c, input logic [1:0] s,
                       input logic [NS-1:0] e, input logic m, input logic t);
      logic [NS-1:0] es, ef;
      logic          erd;
      int            ei;
      bit            sany;
      rst = r; dh = d; ch = c; sr = s; er = e; mb = m; tc = t;
      #1;
      if (r) model_reset();
      sany = (s != 2'b00);
      ei   = oldest(e);
      es = '0; ef = '0; erd = 1'b0;
      if (r) begin
         ef = 5'b11111;
      end else if (m_phase == 0) begin
         if (ei >= 0) ef = 5'(((1 << (ei + 2)) - 1) & ~1);
         else if (sany) es = 5'b11111;
         else if (c) ef = 5'(((1 << (HZ + 1)) - 1) & ~1);
         else if (d) begin es = 5'((1 << HZ) - 1); ef = 5'(1 << HZ); end
      end else if (m_phase == 1) begin
         ef = 5'b11110; es = 5'b00001;
      end else if (m_phase == 2) begin
         es = 5'b00001; ef = m ? 5'b11110 : 5'b00000;
      end else begin
         erd = 1'b1; ef = 5'b00001;
      end
      chk("stall",       32'(o_stall),         32'(es));
      chk("flush",       32'(o_flush),         32'(ef));
      chk("redirect",    32'(o_redirect),      32'(erd));
      chk("trap_stage",  32'(o_trap_stage),    32'(m_trap));
      chk("trap_active", 32'(o_trap_active),   32'(m_phase != 0));
      chk("timeout",     32'(o_stall_timeout), 32'(m_to));
      chk("stall_cycles", o_stall_cycles,      m_cycles);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (es[NS-1]) m_cycles = m_cycles + 32'd1;
         if (sany && m_phase == 0) begin
            m_run = (m_run + 1 > TO) ? TO : m_run + 1;
            if (m_run == TO) m_to = 1;
            else if (t) m_to = 0;
         end else begin
            m_run = 0;
            if (t) m_to = 0;
         end
         case (m_phase)
            0: if (ei >= 0) begin m_trap = ei; m_phase = 1; end
            1: m_phase = 2;
            2: if (!m) m_phase = 3;
            default: m_phase = 0;
         endcase
      end
      @(negedge clk);
   endtask

   initial begin
      dh = 0; ch = 0; sr = 0; er = 0; mb = 0; tc = 0;
      model_reset();
      @(negedge clk);
      // Reset overrides everything
      step(1, 1, 1, 2'b11, 5'b00110, 1, 0);
      step(1, 0, 0, 2'b00, 5'b00000, 0, 0);
      // Hazards
      step(0, 1, 0, 2'b00, 5'b00000, 0, 0);
      step(0, 1, 1, 2'b00, 5'b00000, 0, 0);
      step(0, 0, 1, 2'b00, 5'b00000, 0, 0);
      step(0, 1, 1, 2'b01, 5'b00000, 0, 0);
      step(0, 0, 0, 2'b00, 5'b10000, 0, 0);   // last-stage error is ignored
      // Trap at stage 3 with memory busy, inputs noisy while active
      step(0, 0, 0, 2'b00, 5'b01100, 1, 0);
      step(0, 1, 1, 2'b10, 5'b00011, 1, 0);
      step(0, 1, 0, 2'b01, 5'b00001, 1, 0);
      step(0, 0, 1, 2'b00, 5'b00010, 1, 0);
      step(0, 0, 0, 2'b00, 5'b00000, 0, 0);
      step(0, 0, 0, 2'b00, 5'b00000, 0, 0);   // redirect
      step(0, 0, 0, 2'b00, 5'b00000, 0, 0);
      // Watchdog: 8 stall cycles, then set-vs-clear, then clear
      for (int i = 0; i < TO; i++) step(0, 0, 0, 2'b01, 5'b00000, 0, 0);
      step(0, 0, 0, 2'b10, 5'b00000, 0, 1);
      step(0, 0, 0, 2'b00, 5'b00000, 0, 1);
      step(0, 0, 0, 2'b00, 5'b00000, 0, 0);
      // Reset during drain: no redirect afterwards
      step(0, 0, 0, 2'b00, 5'b00001, 1, 0);
      step(0, 0, 0, 2'b00, 5'b00000, 1, 0);
      step(0, 0, 0, 2'b00, 5'b00000, 1, 0);
      step(1, 0, 0, 2'b00, 5'b00000, 1, 0);
      step(0, 0, 0, 2'b00, 5'b00000, 0, 0);
      step(0, 0, 0, 2'b00, 5'b00000, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [NS-1:0] re;
         logic [1:0]    rs;
         re = ($urandom_range(0, 9) == 0) ? NS'($urandom) : '0;
         rs = ($urandom_range(0, 3) != 0 && i < 200) ? 2'($urandom_range(1, 3)) :
              (($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00);
         step(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom), rs, re,
              1'($urandom), ($urandom_range(0, 9) == 0));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
